// File: rtl/assoc_cache.sv
// Write-back, write-allocate cache (1 or 2 ways, LRU) with a word-serial burst port to memory.
// Define CACHE_STATS_EN to add saturating hit/miss/write-back counters.
module assoc_cache #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 3,
  parameter int WAYS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CPU_read_en,
  input  logic              CPU_write_en,
  input  logic [ADDR_W-1:0] CPU_addr,
  input  logic [DATA_W-1:0] CPU_write_din,
  output logic [DATA_W-1:0] CPU_read_dout,
  output logic              cache_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, DONE} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                victim_q, victim_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdout_q, rdout_d;

  logic [DATA_W-1:0] data_q  [WAYS][SETS][WORDS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic              valid_q [WAYS][SETS];
  logic              dirty_q [WAYS][SETS];
  logic              lru_q   [SETS];

  logic [TAG_W-1:0]    tag_l;
  logic [INDEX_W-1:0]  idx_l;
  logic [OFFSET_W-1:0] off_l;
  logic                hit, hit_way, victim_sel, last_beat;
  logic                fill_we, cpu_we, line_fill, clr_dirty, set_dirty, lru_upd, acc_way;
  logic                lookup_hit, lookup_miss, wb_done;
  logic [TAG_W-1:0]    beat_tag;
  logic                unused_addr;

  assign tag_l       = addr_q[ADDR_W-3 -: TAG_W];
  assign idx_l       = addr_q[OFFSET_W +: INDEX_W];
  assign off_l       = addr_q[OFFSET_W-1:0];
  assign last_beat   = &cnt_q;
  assign unused_addr = ^CPU_addr[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx_l] && tag_q[w][idx_l] == tag_l) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise fall back to the LRU way.
  always_comb begin
    victim_sel = (WAYS > 1) ? lru_q[idx_l] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx_l]) victim_sel = w[0];
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    rdout_d     = rdout_q;
    fill_we     = 1'b0;
    cpu_we      = 1'b0;
    line_fill   = 1'b0;
    clr_dirty   = 1'b0;
    set_dirty   = 1'b0;
    lru_upd     = 1'b0;
    acc_way     = hit_way;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;
    wb_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CPU_read_en || CPU_write_en) begin
          we_d    = CPU_write_en;
          addr_d  = CPU_addr[ADDR_W-1:2];
          wdata_d = CPU_write_din;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          lookup_hit = 1'b1;
          lru_upd    = 1'b1;
          if (we_q) begin
            cpu_we    = 1'b1;
            set_dirty = 1'b1;
          end else begin
            rdout_d = data_q[hit_way][idx_l][off_l];
          end
          state_d = DONE;
        end else begin
          lookup_miss = 1'b1;
          victim_d    = victim_sel;
          cnt_d       = '0;
          state_d     = (valid_q[victim_sel][idx_l] && dirty_q[victim_sel][idx_l]) ? WB : REFILL;
        end
      end
      WB: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            clr_dirty = 1'b1;
            wb_done   = 1'b1;
            state_d   = REFILL;
          end
        end
      end
      REFILL: begin
        if (mem_ack) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (last_beat) begin
            // Complete the original access in the same edge as the final beat.
            line_fill = 1'b1;
            acc_way   = victim_q;
            lru_upd   = 1'b1;
            if (we_q) begin
              cpu_we    = 1'b1;
              set_dirty = 1'b1;
            end else begin
              rdout_d = (off_l == cnt_q) ? mem_rdata : data_q[victim_q][idx_l][off_l];
            end
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      victim_q <= 1'b0;
      cnt_q    <= '0;
      rdout_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      victim_q <= victim_d;
      cnt_q    <= cnt_d;
      rdout_q  <= rdout_d;
    end
  end

  // Later assignment wins, so a CPU write overrides the final refill beat at the same offset.
  always_ff @(posedge clk) begin
    if (fill_we)   data_q[victim_q][idx_l][cnt_q] <= mem_rdata;
    if (cpu_we)    data_q[acc_way][idx_l][off_l]  <= wdata_q;
    if (line_fill) tag_q[victim_q][idx_l]         <= tag_l;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      if (clr_dirty) dirty_q[victim_q][idx_l] <= 1'b0;
      if (line_fill) begin
        valid_q[victim_q][idx_l] <= 1'b1;
        dirty_q[victim_q][idx_l] <= 1'b0;
      end
      if (set_dirty) dirty_q[acc_way][idx_l] <= 1'b1;
      if (lru_upd)   lru_q[idx_l]            <= ~acc_way;
    end
  end

  assign mem_req       = (state_q == WB) || (state_q == REFILL);
  assign mem_we        = (state_q == WB);
  assign beat_tag      = mem_we ? tag_q[victim_q][idx_l] : tag_l;
  assign mem_addr      = mem_req ? {beat_tag, idx_l, cnt_q} : '0;
  assign mem_wdata     = mem_we ? data_q[victim_q][idx_l][cnt_q] : '0;
  assign cache_done    = (state_q == DONE);
  assign CPU_read_dout = rdout_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (lookup_hit  && hit_cnt_q  != '1) hit_cnt_d  = hit_cnt_q  + 32'd1;
    if (lookup_miss && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
    if (wb_done     && wb_cnt_q   != '1) wb_cnt_d   = wb_cnt_q   + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = lookup_hit ^ lookup_miss ^ wb_done;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed scenarios plus random traffic against a timestamp-LRU cache model.
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CPU_read_en = 1'b0, CPU_write_en = 1'b0;
  logic [31:0] CPU_addr = '0, CPU_write_din = '0;
  logic [31:0] CPU_read_dout;
  logic        cache_done, mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk(clk), .rst(rst),
    .CPU_read_en(CPU_read_en), .CPU_write_en(CPU_write_en),
    .CPU_addr(CPU_addr), .CPU_write_din(CPU_write_din),
    .CPU_read_dout(CPU_read_dout), .cache_done(cache_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int errors = 0, checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Main memory seen by the DUT, plus the memory image the model expects.
  typedef struct {logic [29:0] addr; logic [31:0] data;} beat_t;
  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  beat_t       wr_q[$];
  int          rd_beats = 0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst && mem_req && $urandom_range(0, 2) != 0) begin
      mem_ack = 1'b1;
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wr_q.push_back('{addr: mem_addr, data: mem_wdata});
      end else begin
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
        rd_beats++;
      end
    end
  end

  // Reference model: two ways per set, LRU chosen by last-use timestamp.
  logic        m_valid [2][64];
  logic        m_dirty [2][64];
  logic [20:0] m_tag   [2][64];
  logic [31:0] m_data  [2][64][8];
  int          m_stamp [2][64];
  int          stamp_now = 0;
  logic        exp_hit, exp_wb;
  logic [29:0] exp_wb_addr [8];
  logic [31:0] exp_wb_data [8];
  logic [31:0] exp_rdata, last_dout;
  logic        timed_out = 1'b0;

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 64; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
        m_stamp[w][s] = 0;
      end
  endtask

  task automatic model_access(input logic we, input logic [29:0] wa, input logic [31:0] wd);
    logic [20:0] tg;
    logic [5:0]  ix;
    logic [2:0]  of;
    logic [29:0] a;
    int way, v;
    tg = wa[29:9]; ix = wa[8:3]; of = wa[2:0];
    way = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[w][ix] && m_tag[w][ix] == tg) way = w;
    exp_hit = (way >= 0);
    exp_wb  = 1'b0;
    if (!exp_hit) begin
      v = -1;
      for (int w = 1; w >= 0; w--) if (!m_valid[w][ix]) v = w;
      if (v < 0) v = (m_stamp[0][ix] < m_stamp[1][ix]) ? 0 : 1;
      if (m_valid[v][ix] && m_dirty[v][ix]) begin
        exp_wb = 1'b1;
        for (int o = 0; o < 8; o++) begin
          exp_wb_addr[o] = {m_tag[v][ix], ix, 3'(o)};
          exp_wb_data[o] = m_data[v][ix][o];
          ref_mem[exp_wb_addr[o]] = exp_wb_data[o];
        end
      end
      for (int o = 0; o < 8; o++) begin
        a = {tg, ix, 3'(o)};
        m_data[v][ix][o] = ref_mem.exists(a) ? ref_mem[a] : 32'd0;
      end
      m_valid[v][ix] = 1'b1;
      m_dirty[v][ix] = 1'b0;
      m_tag[v][ix]   = tg;
      way = v;
    end
    if (we) begin
      m_data[way][ix][of] = wd;
      m_dirty[way][ix]    = 1'b1;
    end else begin
      exp_rdata = m_data[way][ix][of];
    end
    stamp_now++;
    m_stamp[way][ix] = stamp_now;
  endtask

  task automatic cpu_access(input logic rd, input logic wr, input logic [20:0] tg,
                            input logic [5:0] ix, input logic [2:0] of, input logic [31:0] din);
    logic [29:0] wa;
    int cyc;
    wa = {tg, ix, of};
    @(negedge clk);
    rd_beats = 0;
    wr_q.delete();
    CPU_read_en = rd; CPU_write_en = wr; CPU_addr = {wa, 2'b00}; CPU_write_din = din;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!cache_done && cyc < 600);
    last_dout = CPU_read_dout;
    CPU_read_en = 1'b0; CPU_write_en = 1'b0;
    if (!cache_done) begin
      check_val("done_timeout", 32'd0, 32'd1);
      timed_out = 1'b1;
      return;
    end
    model_access(wr, wa, din);
    if (exp_hit) check_val("hit_latency", cyc, 32'd2);
    check_val("read_beats", rd_beats, exp_hit ? 32'd0 : 32'd8);
    check_val("wb_beats", wr_q.size(), exp_wb ? 32'd8 : 32'd0);
    if (exp_wb)
      for (int i = 0; i < wr_q.size() && i < 8; i++) begin
        check_val("wb_addr", {2'b00, wr_q[i].addr}, {2'b00, exp_wb_addr[i]});
        check_val("wb_data", wr_q[i].data, exp_wb_data[i]);
      end
    if (!wr) check_val("read_data", last_dout, exp_rdata);
    @(posedge clk);
  endtask

  initial begin
    logic [20:0] tg;
    logic [5:0]  ix;
    logic [29:0] a;
    logic [31:0] val;
    logic        done_seen;
    int          n, op;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_done", cache_done, 0);
    check_val("rst_req", mem_req, 0);
    check_val("rst_we", mem_we, 0);
    check_val("rst_addr", {2'b00, mem_addr}, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_dout", CPU_read_dout, 0);
    @(negedge clk) rst = 1'b0;

    for (int o = 0; o < 8; o++) cpu_access(1'b0, 1'b1, 21'd1, 6'd15, 3'(o), 32'd100 + o);
    for (int o = 0; o < 8; o++) cpu_access(1'b0, 1'b1, 21'd2, 6'd15, 3'(o), 32'd300 + o);
    for (int o = 0; o < 8; o++) begin
      cpu_access(1'b1, 1'b0, 21'd1, 6'd15, 3'(o), 32'd0);
      check_val("way0_data", last_dout, 32'd100 + o);
    end

    cpu_access(1'b0, 1'b1, 21'd3, 6'd15, 3'd0, 32'h55);
    check_val("evict_addr0", wr_q.size() > 0 ? {2'b00, wr_q[0].addr} : 32'hFFFF_FFFF,
              {11'd0, 21'd2} << 9 | (32'd15 << 3));
    check_val("evict_data7", wr_q.size() > 7 ? wr_q[7].data : 32'hFFFF_FFFF, 32'd307);

    for (int o = 0; o < 8; o++) begin
      a = {21'd1, 6'd20, 3'(o)};
      val = $urandom;
      mem[a] = val;
      ref_mem[a] = val;
    end
    cpu_access(1'b1, 1'b0, 21'd1, 6'd20, 3'd5, 32'd0);
    check_val("clean_miss_val", last_dout, ref_mem[{21'd1, 6'd20, 3'd5}]);
    cpu_access(1'b1, 1'b0, 21'd1, 6'd20, 3'd5, 32'd0);

    // Reset in the middle of a refill burst.
    @(negedge clk);
    rd_beats = 0;
    wr_q.delete();
    CPU_read_en = 1'b1; CPU_addr = {21'd5, 6'd7, 3'd1, 2'b00};
    n = 0;
    while (rd_beats < 4 && n < 600) begin
      @(posedge clk); #2;
      n++;
    end
    check_val("reached_beat4", rd_beats >= 4, 1);
    rst = 1'b1;
    CPU_read_en = 1'b0;
    @(posedge clk); #1;
    check_val("req_after_rst", mem_req, 0);
    done_seen = cache_done;
    @(negedge clk) rst = 1'b0;
    model_reset();
    repeat (6) begin
      @(posedge clk); #1;
      done_seen |= cache_done;
    end
    check_val("no_done_after_rst", done_seen, 0);
    cpu_access(1'b1, 1'b0, 21'd5, 6'd7, 3'd1, 32'd0);
    check_val("remiss_beats", rd_beats, 8);

    cpu_access(1'b1, 1'b1, 21'd1, 6'd15, 3'd2, 32'hDEAD);
    cpu_access(1'b1, 1'b0, 21'd1, 6'd15, 3'd2, 32'd0);
    check_val("rw_both", last_dout, 32'hDEAD);

    for (int t = 0; t < 4; t++)
      for (int o = 0; o < 8; o++) begin
        val = $urandom;
        a = {21'(t), 6'd3, 3'(o)};
        mem[a] = val; ref_mem[a] = val;
        val = $urandom;
        a = {21'(t), 6'd40, 3'(o)};
        mem[a] = val; ref_mem[a] = val;
      end
    for (int k = 0; k < 200 && !timed_out; k++) begin
      tg = 21'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       ix = 6'd3;
        1:       ix = 6'd15;
        default: ix = 6'd40;
      endcase
      op = $urandom_range(0, 2);
      cpu_access(op != 1, op != 0, tg, ix, 3'($urandom_range(0, 7)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
